// File: rtl/riscv_tb_pkg.sv
// Shared types for the RISC-V self-check monitor: status encoding and the
// checkpoint record stored in the expectation table.
package riscv_tb_pkg;

    // The checkpoint record is sized for the widest supported NUM_INST / OUTPUT_PORT.
    // Narrower configurations zero-extend into it, so the upper bits stay constant.
    localparam int CKPT_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } status_e;

    typedef struct packed {
        logic [CKPT_W-1:0] num_inst;
        logic [CKPT_W-1:0] ans;
        logic [CKPT_W-1:0] mask;
    } ckpt_t;

endpackage

// File: rtl/riscv_test_checker_if.sv
// Load, core-observation and result signals of the checker, bundled for one connection.
interface riscv_test_checker_if #(
    parameter int NUM_TEST = 32,
    parameter int DWIDTH   = 32,
    parameter int CWIDTH   = 32
);
    localparam int IW   = $clog2(NUM_TEST);
    localparam int CNTW = $clog2(NUM_TEST + 1);

    logic              LOAD_EN;
    logic [IW-1:0]     LOAD_IDX;
    logic [CWIDTH-1:0] LOAD_NUM_INST;
    logic [DWIDTH-1:0] LOAD_ANS;
    logic [DWIDTH-1:0] LOAD_MASK;
    logic [CNTW-1:0]   NUM_VALID;
    logic              START;
    logic [CWIDTH-1:0] NUM_INST;
    logic [DWIDTH-1:0] OUTPUT_PORT;
    logic              HALT;
    logic [2:0]        STATUS;
    logic              CHK_VALID;
    logic              CHK_OK;
    logic [IW-1:0]     FAIL_IDX;
    logic [DWIDTH-1:0] FAIL_VAL;
    logic [CNTW-1:0]   PASS_CNT;
    logic [CNTW-1:0]   FAIL_CNT;
    logic [CWIDTH-1:0] CYCLE_CNT;

    // Testbench / core side
    modport master (
        output LOAD_EN, LOAD_IDX, LOAD_NUM_INST, LOAD_ANS, LOAD_MASK, NUM_VALID, START,
               NUM_INST, OUTPUT_PORT, HALT,
        input  STATUS, CHK_VALID, CHK_OK, FAIL_IDX, FAIL_VAL, PASS_CNT, FAIL_CNT, CYCLE_CNT
    );

    // Checker side
    modport slave (
        input  LOAD_EN, LOAD_IDX, LOAD_NUM_INST, LOAD_ANS, LOAD_MASK, NUM_VALID, START,
               NUM_INST, OUTPUT_PORT, HALT,
        output STATUS, CHK_VALID, CHK_OK, FAIL_IDX, FAIL_VAL, PASS_CNT, FAIL_CNT, CYCLE_CNT
    );
endinterface

// File: rtl/riscv_ckpt_table.sv
// Checkpoint expectation table: one write port, asynchronous read at the walk pointer.
// Contents survive reset so a test can be re-run without reloading.
module riscv_ckpt_table
    import riscv_tb_pkg::*;
#(
    parameter int NUM_TEST = 32
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [$clog2(NUM_TEST)-1:0] wr_idx,
    input  ckpt_t                       wr_entry,
    input  logic [$clog2(NUM_TEST)-1:0] rd_idx,
    output ckpt_t                       rd_entry
);
    ckpt_t mem_q [NUM_TEST];

    // Table write; no reset on purpose
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_idx] <= wr_entry;
        end
    end

    assign rd_entry = mem_q[rd_idx];
endmodule

// File: rtl/riscv_test_checker.sv
// Self-check monitor beside a RISC-V core: walks the checkpoint table in order as
// NUM_INST advances, compares masked OUTPUT_PORT values, flags skipped checkpoints,
// and finishes in PASS / FAIL / TIMEOUT with diagnostic counters.
module riscv_test_checker
    import riscv_tb_pkg::*;
#(
    parameter int NUM_TEST     = 32,
    parameter int DWIDTH       = 32,
    parameter int CWIDTH       = 32,
    parameter int TIMEOUT      = 1000000,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input logic                CLK,
    input logic                RST,
    riscv_test_checker_if.slave bus
);
    localparam int                IW      = $clog2(NUM_TEST);
    localparam int                CNTW    = $clog2(NUM_TEST + 1);
    localparam logic [CNTW-1:0]   CNT_MAX = '1;
    localparam logic [CNTW-1:0]   NT      = CNTW'(NUM_TEST);
    localparam logic [CWIDTH-1:0] CYC_MAX = '1;
    localparam logic [CWIDTH-1:0] TO_LAST = CWIDTH'(TIMEOUT - 1);

    status_e           state_q, state_d;
    logic [CNTW-1:0]   ptr_q, ptr_d;
    logic [CNTW-1:0]   nvalid_q, nvalid_d;
    logic [CNTW-1:0]   pass_cnt_q, pass_cnt_d;
    logic [CNTW-1:0]   fail_cnt_q, fail_cnt_d;
    logic [IW-1:0]     fail_idx_q, fail_idx_d;
    logic [DWIDTH-1:0] fail_val_q, fail_val_d;
    logic [CWIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
    logic              chk_valid_q, chk_valid_d;
    logic              chk_ok_q, chk_ok_d;

    ckpt_t             wr_entry, rd_entry;
    logic              active, hit, miss, ok, fail_now;
    logic [CNTW-1:0]   remaining;
    logic [CNTW:0]     fail_sum;
    logic [CKPT_W-1:0] ni_x, out_x;

    assign wr_entry = '{num_inst: CKPT_W'(bus.LOAD_NUM_INST),
                        ans:      CKPT_W'(bus.LOAD_ANS),
                        mask:     CKPT_W'(bus.LOAD_MASK)};
    assign ni_x  = CKPT_W'(bus.NUM_INST);
    assign out_x = CKPT_W'(bus.OUTPUT_PORT);

    riscv_ckpt_table #(.NUM_TEST(NUM_TEST)) u_table (
        .clk      (CLK),
        .we       (bus.LOAD_EN && (state_q == ST_IDLE)),
        .wr_idx   (bus.LOAD_IDX),
        .wr_entry (wr_entry),
        .rd_idx   (ptr_q[IW-1:0]),
        .rd_entry (rd_entry)
    );

    // Next-state: START handling, per-cycle checkpoint walk, halt/timeout resolution
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        nvalid_d    = nvalid_q;
        pass_cnt_d  = pass_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        fail_idx_d  = fail_idx_q;
        fail_val_d  = fail_val_q;
        cycle_cnt_d = cycle_cnt_q;
        chk_valid_d = 1'b0;
        chk_ok_d    = chk_ok_q;
        active      = 1'b0;
        hit         = 1'b0;
        miss        = 1'b0;
        ok          = 1'b0;
        fail_now    = 1'b0;
        remaining   = '0;
        fail_sum    = '0;

        case (state_q)
            ST_RUN: begin
                cycle_cnt_d = (cycle_cnt_q == CYC_MAX) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
                active = ptr_q < nvalid_q;
                hit    = active && (ni_x == rd_entry.num_inst);
                // Core retired past the checkpoint without ever showing its count
                miss   = active && (ni_x > rd_entry.num_inst);
                ok     = hit && (((out_x ^ rd_entry.ans) & rd_entry.mask) == '0);
                if (hit || miss) begin
                    chk_valid_d = 1'b1;
                    chk_ok_d    = ok;
                    ptr_d       = ptr_q + 1'b1;
                    if (ok) begin
                        pass_cnt_d = (pass_cnt_q == CNT_MAX) ? pass_cnt_q : pass_cnt_q + 1'b1;
                    end else begin
                        fail_now   = 1'b1;
                        fail_cnt_d = (fail_cnt_q == CNT_MAX) ? fail_cnt_q : fail_cnt_q + 1'b1;
                        if (fail_cnt_q == '0) begin
                            fail_idx_d = ptr_q[IW-1:0];
                            fail_val_d = bus.OUTPUT_PORT;
                        end
                    end
                end

                if (STOP_ON_FAIL && fail_now) begin
                    state_d = ST_FAIL;
                end else if (bus.HALT) begin
                    // Every checkpoint still ahead of the pointer was never reached
                    remaining = nvalid_q - ptr_d;
                    if (remaining != '0) begin
                        if (fail_cnt_d == '0) begin
                            fail_idx_d = ptr_d[IW-1:0];
                            fail_val_d = bus.OUTPUT_PORT;
                        end
                        fail_sum   = {1'b0, fail_cnt_d} + {1'b0, remaining};
                        fail_cnt_d = fail_sum[CNTW] ? CNT_MAX : fail_sum[CNTW-1:0];
                    end
                    state_d = (fail_cnt_d == '0) ? ST_PASS : ST_FAIL;
                end else if ((TIMEOUT != 0) && (cycle_cnt_q == TO_LAST)) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: begin
                // IDLE and terminal states: START begins a fresh run on the current table
                if (bus.START) begin
                    state_d     = ST_RUN;
                    ptr_d       = '0;
                    nvalid_d    = (bus.NUM_VALID > NT) ? NT : bus.NUM_VALID;
                    pass_cnt_d  = '0;
                    fail_cnt_d  = '0;
                    fail_idx_d  = '0;
                    fail_val_d  = '0;
                    cycle_cnt_d = '0;
                    chk_ok_d    = 1'b0;
                end
            end
        endcase
    end

    // State and statistics registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            nvalid_q    <= '0;
            pass_cnt_q  <= '0;
            fail_cnt_q  <= '0;
            fail_idx_q  <= '0;
            fail_val_q  <= '0;
            cycle_cnt_q <= '0;
            chk_valid_q <= 1'b0;
            chk_ok_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            nvalid_q    <= nvalid_d;
            pass_cnt_q  <= pass_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            fail_idx_q  <= fail_idx_d;
            fail_val_q  <= fail_val_d;
            cycle_cnt_q <= cycle_cnt_d;
            chk_valid_q <= chk_valid_d;
            chk_ok_q    <= chk_ok_d;
        end
    end

    assign bus.STATUS    = state_q;
    assign bus.CHK_VALID = chk_valid_q;
    assign bus.CHK_OK    = chk_ok_q;
    assign bus.FAIL_IDX  = fail_idx_q;
    assign bus.FAIL_VAL  = fail_val_q;
    assign bus.PASS_CNT  = pass_cnt_q;
    assign bus.FAIL_CNT  = fail_cnt_q;
    assign bus.CYCLE_CNT = cycle_cnt_q;
endmodule

// File: tb/tb_riscv_test_checker.sv
// Bench for riscv_test_checker. Three instances share one stimulus stream:
// dut0 stops on fail, dut1 continues on fail, dut2 stops on fail with TIMEOUT=20.
module tb_riscv_test_checker;
    import riscv_tb_pkg::*;

    localparam int NT = 32, DW = 32, CW = 32, ND = 3;

    logic clk, rst;
    logic load_en, start, halt;
    logic [4:0]  load_idx;
    logic [31:0] load_num, load_ans, load_mask, num_inst, out_port;
    logic [5:0]  num_valid;

    logic [2:0]  o_status [ND];
    logic        o_cv [ND], o_ok [ND];
    logic [4:0]  o_fidx [ND];
    logic [31:0] o_fval [ND], o_cyc [ND];
    logic [5:0]  o_pass [ND], o_fail [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        riscv_test_checker_if #(.NUM_TEST(NT), .DWIDTH(DW), .CWIDTH(CW)) bus_if ();
        assign bus_if.LOAD_EN       = load_en;
        assign bus_if.LOAD_IDX      = load_idx;
        assign bus_if.LOAD_NUM_INST = load_num;
        assign bus_if.LOAD_ANS      = load_ans;
        assign bus_if.LOAD_MASK     = load_mask;
        assign bus_if.NUM_VALID     = num_valid;
        assign bus_if.START         = start;
        assign bus_if.NUM_INST      = num_inst;
        assign bus_if.OUTPUT_PORT   = out_port;
        assign bus_if.HALT          = halt;
        assign o_status[g] = bus_if.STATUS;
        assign o_cv[g]     = bus_if.CHK_VALID;
        assign o_ok[g]     = bus_if.CHK_OK;
        assign o_fidx[g]   = bus_if.FAIL_IDX;
        assign o_fval[g]   = bus_if.FAIL_VAL;
        assign o_pass[g]   = bus_if.PASS_CNT;
        assign o_fail[g]   = bus_if.FAIL_CNT;
        assign o_cyc[g]    = bus_if.CYCLE_CNT;
        riscv_test_checker #(.NUM_TEST(NT), .DWIDTH(DW), .CWIDTH(CW),
                             .TIMEOUT(g == 2 ? 20 : 0),
                             .STOP_ON_FAIL(g == 1 ? 1'b0 : 1'b1)) u_dut (
            .CLK (clk),
            .RST (rst),
            .bus (bus_if)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;
    string scn;

    // Scenario: checkpoint table and per-cycle core trace
    int          nv;
    logic [31:0] t_num [NT], t_ans [NT], t_mask [NT];
    int          tr_len;
    logic [31:0] tr_ni [64], tr_out [64];
    bit          tr_halt [64];

    // Reference model state per instance
    logic [2:0]  m_st [ND];
    int          m_cyc [ND], m_pass [ND], m_fail [ND], m_fidx [ND], m_next [ND];
    logic [31:0] m_fval [ND];
    bit          exp_v [ND], exp_ok [ND];

    function automatic void set_ent(input int e, input logic [31:0] n, a, m);
        t_num[e] = n; t_ans[e] = a; t_mask[e] = m;
    endfunction

    function automatic void set_tr(input int c, input logic [31:0] n, o, input bit h);
        tr_ni[c] = n; tr_out[c] = o; tr_halt[c] = h;
    endfunction

    function automatic void model_fail(input int d, input int e, input logic [31:0] v);
        if (m_fail[d] == 0) begin
            m_fidx[d] = e;
            m_fval[d] = v;
        end
        m_fail[d]++;
    endfunction

    // One RUN cycle of the checker rules for instance d
    function automatic void model_cycle(input int d, input logic [31:0] ni, ov, input bit h);
        bit failed;
        int e;
        failed = 0;
        exp_v[d] = 0;
        exp_ok[d] = 0;
        if (m_st[d] != ST_RUN) return;
        m_cyc[d]++;
        e = m_next[d];
        if (e < nv && ni >= t_num[e]) begin
            exp_v[d]  = 1;
            exp_ok[d] = (ni == t_num[e]) && (((ov ^ t_ans[e]) & t_mask[e]) == 32'd0);
            if (exp_ok[d]) m_pass[d]++;
            else begin
                model_fail(d, e, ov);
                failed = 1;
            end
            m_next[d]++;
        end
        if (failed && d != 1) m_st[d] = ST_FAIL;
        else if (h) begin
            for (int k = m_next[d]; k < nv; k++) model_fail(d, k, ov);
            m_next[d] = nv;
            m_st[d] = (m_fail[d] == 0) ? ST_PASS : ST_FAIL;
        end else if (d == 2 && m_cyc[d] == 20) m_st[d] = ST_TIMEOUT;
    endfunction

    // Optionally reset+load, START, play the trace, then check final counters
    task automatic do_run(input bit fresh);
        num_inst = 0; out_port = 0; halt = 0;
        if (fresh) begin
            rst = 1;
            @(negedge clk);
            rst = 0;
            for (int d = 0; d < ND; d++) m_st[d] = ST_IDLE;
            for (int e = 0; e < nv; e++) begin
                load_en = 1; load_idx = 5'(e);
                load_num = t_num[e]; load_ans = t_ans[e]; load_mask = t_mask[e];
                num_valid = 6'(nv);
                start = (e == nv - 1);
                @(negedge clk);
            end
        end
        if (!fresh || nv == 0) begin
            num_valid = 6'(nv); start = 1;
            @(negedge clk);
        end
        load_en = 0; start = 0;
        for (int d = 0; d < ND; d++) begin
            if (m_st[d] != ST_RUN) begin
                m_st[d] = ST_RUN; m_cyc[d] = 0; m_pass[d] = 0; m_fail[d] = 0;
                m_fidx[d] = 0; m_fval[d] = 0; m_next[d] = 0;
            end
        end
        for (int c = 0; c < tr_len; c++) begin
            num_inst = tr_ni[c]; out_port = tr_out[c]; halt = tr_halt[c];
            for (int d = 0; d < ND; d++) model_cycle(d, tr_ni[c], tr_out[c], tr_halt[c]);
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                n_checks++;
                if (o_status[d] !== m_st[d]) begin
                    n_errors++;
                    $display("FAIL %s dut%0d c%0d status got %0d exp %0d", scn, d, c, o_status[d], m_st[d]);
                end
                n_checks++;
                if (o_cv[d] !== exp_v[d]) begin
                    n_errors++;
                    $display("FAIL %s dut%0d c%0d chk_valid got %0b exp %0b", scn, d, c, o_cv[d], exp_v[d]);
                end
                if (exp_v[d]) begin
                    n_checks++;
                    if (o_ok[d] !== exp_ok[d]) begin
                        n_errors++;
                        $display("FAIL %s dut%0d c%0d chk_ok got %0b exp %0b", scn, d, c, o_ok[d], exp_ok[d]);
                    end
                end
            end
        end
        halt = 0;
        for (int d = 0; d < ND; d++) begin
            n_checks++;
            if (o_pass[d] !== 6'(m_pass[d]) || o_fail[d] !== 6'(m_fail[d]) || o_cyc[d] !== 32'(m_cyc[d])) begin
                n_errors++;
                $display("FAIL %s dut%0d counters got pass=%0d fail=%0d cyc=%0d exp pass=%0d fail=%0d cyc=%0d",
                         scn, d, o_pass[d], o_fail[d], o_cyc[d], m_pass[d], m_fail[d], m_cyc[d]);
            end
            n_checks++;
            if (o_fidx[d] !== 5'(m_fidx[d]) || o_fval[d] !== m_fval[d]) begin
                n_errors++;
                $display("FAIL %s dut%0d fail_info got idx=%0d val=%h exp idx=%0d val=%h",
                         scn, d, o_fidx[d], o_fval[d], m_fidx[d], m_fval[d]);
            end
        end
    endtask

    task automatic test_reset();
        scn = "reset";
        rst = 1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            n_checks++;
            if ({o_status[d], o_cv[d], o_ok[d], o_fidx[d], o_fval[d], o_pass[d], o_fail[d], o_cyc[d]} !== '0) begin
                n_errors++;
                $display("FAIL reset dut%0d outputs got st=%0d pass=%0d fail=%0d cyc=%0d exp all zero",
                         d, o_status[d], o_pass[d], o_fail[d], o_cyc[d]);
            end
        end
        rst = 0;
    endtask

    task automatic test_basic_pass();
        scn = "basic_pass";
        nv = 3;
        set_ent(0, 1, 5, 32'hFFFF_FFFF); set_ent(1, 2, 0, 32'hFFFF_FFFF); set_ent(2, 3, 1, 32'hFFFF_FFFF);
        tr_len = 5;
        set_tr(0, 0, 9, 0); set_tr(1, 1, 5, 0); set_tr(2, 2, 0, 0); set_tr(3, 3, 1, 0); set_tr(4, 4, 7, 1);
        do_run(1);
    endtask

    task automatic test_restart();
        // Table persists; a load outside IDLE must be ignored
        scn = "restart";
        load_en = 1; load_idx = 0; load_num = 99; load_ans = 32'hDEAD; load_mask = '1;
        @(negedge clk);
        load_en = 0;
        do_run(0);
    endtask

    task automatic test_stop_fail();
        scn = "stop_fail";
        nv = 1;
        set_ent(0, 5, 32'h1E, 32'hFFFF_FFFF);
        tr_len = 4;
        set_tr(0, 3, 0, 0); set_tr(1, 4, 0, 0); set_tr(2, 5, 32'h1F, 0); set_tr(3, 6, 0, 1);
        do_run(1);
    endtask

    task automatic test_continue();
        scn = "continue";
        nv = 4;
        for (int e = 0; e < 4; e++) set_ent(e, 32'(e + 1), 32'(10 * (e + 1)), 32'hFFFF_FFFF);
        tr_len = 6;
        set_tr(0, 0, 0, 0); set_tr(1, 1, 11, 0); set_tr(2, 2, 20, 0);
        set_tr(3, 3, 31, 0); set_tr(4, 4, 40, 0); set_tr(5, 5, 0, 1);
        do_run(1);
    endtask

    task automatic test_mask_miss();
        scn = "mask_miss";
        nv = 2;
        set_ent(0, 6, 32'h5, 32'h0000_000F); set_ent(1, 7, 32'h77, 32'hFFFF_FFFF);
        tr_len = 4;
        set_tr(0, 5, 0, 0); set_tr(1, 6, 32'hABCD_0005, 0); set_tr(2, 8, 32'h123, 0); set_tr(3, 9, 0, 1);
        do_run(1);
    endtask

    task automatic test_timeout();
        scn = "timeout";
        nv = 1;
        set_ent(0, 3, 32'h33, 32'hFFFF_FFFF);
        tr_len = 25;
        for (int c = 0; c < 25; c++) set_tr(c, 32'(c), (c == 3) ? 32'h33 : 32'h0, 0);
        do_run(1);
    endtask

    task automatic test_reset_midrun();
        scn = "reset_midrun";
        nv = 2;
        set_ent(0, 100, 1, '1); set_ent(1, 200, 2, '1);
        tr_len = 10;
        for (int c = 0; c < 10; c++) set_tr(c, 0, 0, 0);
        do_run(1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        for (int d = 0; d < ND; d++) begin
            m_st[d] = ST_IDLE;
            n_checks++;
            if ({o_status[d], o_cv[d], o_ok[d], o_fidx[d], o_fval[d], o_pass[d], o_fail[d], o_cyc[d]} !== '0) begin
                n_errors++;
                $display("FAIL reset_midrun dut%0d outputs got st=%0d cyc=%0d exp all zero", d, o_status[d], o_cyc[d]);
            end
        end
    endtask

    task automatic test_halt_edges();
        scn = "halt_on_last";
        nv = 2;
        set_ent(0, 1, 4, '1); set_ent(1, 2, 8, '1);
        tr_len = 3;
        set_tr(0, 0, 0, 0); set_tr(1, 1, 4, 0); set_tr(2, 2, 8, 1);
        do_run(1);
        scn = "halt_unreached";
        nv = 4;
        for (int e = 0; e < 4; e++) set_ent(e, 32'(e + 1), 32'(e + 1), '1);
        tr_len = 4;
        set_tr(0, 0, 0, 0); set_tr(1, 1, 1, 0); set_tr(2, 2, 2, 0); set_tr(3, 2, 32'h55, 1);
        do_run(1);
    endtask

    task automatic test_back_to_back();
        // Two checkpoints on one instruction count take consecutive cycles
        scn = "back_to_back";
        nv = 2;
        set_ent(0, 3, 7, '1); set_ent(1, 3, 9, '1);
        tr_len = 4;
        set_tr(0, 1, 0, 0); set_tr(1, 3, 7, 0); set_tr(2, 3, 9, 0); set_tr(3, 4, 0, 1);
        do_run(1);
    endtask

    task automatic test_random();
        logic [31:0] n, ni;
        bit found;
        for (int it = 0; it < 12; it++) begin
            scn = "random";
            nv = $urandom_range(0, 8);
            n = $urandom_range(1, 3);
            for (int e = 0; e < nv; e++) begin
                set_ent(e, n, $urandom, ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom);
                n = n + $urandom_range(0, 2);
            end
            tr_len = $urandom_range(8, 30);
            ni = 0;
            for (int c = 0; c < tr_len; c++) begin
                tr_ni[c] = ni;
                tr_out[c] = $urandom;
                found = 0;
                for (int e = 0; e < nv; e++) begin
                    if (!found && t_num[e] == ni && $urandom_range(0, 4) != 0) begin
                        tr_out[c] = t_ans[e];
                        found = 1;
                    end
                end
                tr_halt[c] = (c == tr_len - 1);
                ni = ni + $urandom_range(0, 2);
            end
            do_run(1);
        end
    endtask

    initial begin
        rst = 1; load_en = 0; start = 0; halt = 0;
        load_idx = 0; load_num = 0; load_ans = 0; load_mask = 0;
        num_valid = 0; num_inst = 0; out_port = 0;
        test_reset();
        test_basic_pass();
        test_restart();
        test_stop_fail();
        test_continue();
        test_mask_miss();
        test_timeout();
        test_reset_midrun();
        test_halt_edges();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/riscv_test_checker.md
Name: riscv_test_checker

Overview:
Parametrised, synthesizable-style self-check monitor for RISC-V core simulations. It holds a loadable table of expected (instruction-count, output-value, mask) checkpoints. It watches the core's NUM_INST, OUTPUT_PORT and HALT, and reports pass, fail or timeout with diagnostic counters. It sits beside RISCV_TOP in every lab testbench and replaces hand-written per-test compare loops. It adds in-order checkpoint walking, masked compares, miss detection, a timeout watchdog and a continue-on-fail mode.

Parameters:
NUM_TEST, 32, checkpoint table depth.
DWIDTH, 32, width of OUTPUT_PORT and expected values.
CWIDTH, 32, width of NUM_INST and cycle counters.
TIMEOUT, 1000000, cycles in RUN before timeout; 0 disables the watchdog.
STOP_ON_FAIL, 1, 1 = stop at first failing checkpoint; 0 = record and continue.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous, active-high reset
LOAD_EN  in  1  write one table entry (accepted only in IDLE)
LOAD_IDX  in  $clog2(NUM_TEST)  entry index
LOAD_NUM_INST  in  CWIDTH  instruction count at which the check fires
LOAD_ANS  in  DWIDTH  expected OUTPUT_PORT
LOAD_MASK  in  DWIDTH  compare mask (1 = bit checked)
NUM_VALID  in  $clog2(NUM_TEST+1)  number of loaded entries; sampled on START
START  in  1  one-cycle pulse: clear stats and enter RUN
NUM_INST  in  CWIDTH  core retired-instruction count
OUTPUT_PORT  in  DWIDTH  core output port
HALT  in  1  core halt
STATUS  out  3  0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT
CHK_VALID  out  1  one-cycle pulse per evaluated checkpoint
CHK_OK  out  1  result of the evaluated checkpoint; qualified by CHK_VALID
FAIL_IDX  out  $clog2(NUM_TEST)  index of the first failing or missed entry
FAIL_VAL  out  DWIDTH  OUTPUT_PORT captured at the first failure
PASS_CNT  out  $clog2(NUM_TEST+1)  checkpoints passed
FAIL_CNT  out  $clog2(NUM_TEST+1)  checkpoints failed or missed
CYCLE_CNT  out  CWIDTH  cycles spent in RUN

Behaviour:
- Reset (RST=1 at a clock edge): STATUS=IDLE. All counters, FAIL_IDX, FAIL_VAL, CHK_VALID, CHK_OK and the pointer are 0. Table contents are not cleared.
- Reset during RUN aborts the run with the same result.
- IDLE:
  - LOAD_EN writes the entry at LOAD_IDX.
  - START latches NUM_VALID (clamped to NUM_TEST), clears stats and ptr, and moves to RUN on the next cycle.
  - LOAD_EN and START in the same cycle: the load completes first.
- RUN, evaluated every cycle, in this priority:
  1. CYCLE_CNT increments.
  2. If ptr < nvalid and NUM_INST == exp_num[ptr]:
     - ok = ((OUTPUT_PORT ^ ans[ptr]) & mask[ptr]) == 0.
     - CHK_VALID=1 and CHK_OK=ok on the next cycle (registered, latency 1).
     - ok: PASS_CNT++, ptr++.
     - not ok: FAIL_CNT++; FAIL_IDX and FAIL_VAL are captured if this is the first failure; ptr++.
  3. Miss: if ptr < nvalid and NUM_INST > exp_num[ptr], the core skipped the checkpoint. Treat it as a failure with FAIL_VAL = OUTPUT_PORT and CHK_OK=0.
  4. HALT is evaluated after the same-cycle checkpoint. Remaining entries (ptr < nvalid after the update) each count as a miss; FAIL_IDX = ptr if this is the first failure. Then STATUS = (FAIL_CNT==0) ? PASS : FAIL.
  5. If STOP_ON_FAIL=1, any failure moves to FAIL immediately; HALT in the same cycle is ignored.
  6. If TIMEOUT != 0 and CYCLE_CNT == TIMEOUT-1 with no HALT, go to TIMEOUT. A same-cycle checkpoint is still evaluated first.
- At most one checkpoint is evaluated per cycle. If two entries share a NUM_INST value, the second is evaluated the following cycle, provided NUM_INST is unchanged.
- Terminal states (PASS, FAIL, TIMEOUT): all outputs hold. START re-enters RUN with cleared stats and the existing table. LOAD_EN is ignored outside IDLE; return to IDLE is by RST only.
- nvalid=0: RUN just waits for HALT (giving PASS) or timeout.
- Counters saturate; they never wrap.

Decomposition:
- Package riscv_tb_pkg: status encoding constants and the checkpoint struct typedef {num_inst, ans, mask}.
- One sub-module, riscv_ckpt_table: NUM_TEST-deep register array with a write port and an asynchronous read at ptr.

Test Plan:
- Load 3 entries {(1,5,FFFFFFFF),(2,0,FFFFFFFF),(3,1,FFFFFFFF)}; drive matching outputs, HALT at NUM_INST=4 -> three CHK_OK pulses, PASS_CNT=3, STATUS=PASS.
- Entry (5,0x1E), OUTPUT_PORT=0x1F at NUM_INST=5, STOP_ON_FAIL=1 -> STATUS=FAIL on the next cycle, FAIL_IDX=0, FAIL_VAL=0x1F, FAIL_CNT=1.
- STOP_ON_FAIL=0 with entries 0 and 2 wrong out of 4 -> run continues to HALT, FAIL_CNT=2, PASS_CNT=2, FAIL_IDX=0, STATUS=FAIL.
- Mask 0x0000000F, ans 0x5, OUTPUT_PORT 0xABCD0005 -> CHK_OK=1. NUM_INST jumps 6→8 past entry 7 -> miss, FAIL_IDX of that entry.
- TIMEOUT=20, HALT never asserted -> STATUS=TIMEOUT with CYCLE_CNT=20. RST mid-RUN at cycle 10 -> STATUS=IDLE, all counters 0.
- HALT in the same cycle as the last checkpoint match -> checkpoint counted, STATUS=PASS. HALT with 2 entries unreached -> FAIL_CNT=2.
